// File: rtl/lift_call_dispatch.sv
// Hall/cabin call dispatcher for a single lift: latches button presses, picks the
// nearest pending floor and sequences CALL -> RIDE -> DONE with abandon timeouts.
module lift_call_dispatch #(
    parameter int NUM_FLOORS = 7,
    parameter int ARRIVE_TMO = 64,
    parameter int RIDE_WAIT  = 32,
    localparam int FW = $clog2(NUM_FLOORS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_btn,
    input  logic [NUM_FLOORS-1:0] cab_btn,
    input  logic [FW-1:0]         elev_f_i,
    input  logic                  busy_i,
    output logic [FW-1:0]         pass_f_o,
    output logic [FW-1:0]         butt_el_o,
    output logic [NUM_FLOORS-1:0] hall_pend_o,
    output logic [NUM_FLOORS-1:0] cab_pend_o,
    output logic                  done_o,
    output logic                  tmo_o
);

    localparam int TMAX = (ARRIVE_TMO > RIDE_WAIT) ? ARRIVE_TMO : RIDE_WAIT;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] TMO_LAST  = CW'(ARRIVE_TMO - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RIDE_WAIT - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        RIDE = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;

    logic            elev_valid_s;
    logic            call_arrive_s;
    logic            ride_arrive_s;
    logic [FW-1:0]   hall_sel_s;
    logic [FW-1:0]   cab_sel_s;
    logic [NUM_FLOORS-1:0] hall_clr_s;
    logic [NUM_FLOORS-1:0] cab_clr_s;

    // Nearest pending floor; ascending scan with strict compare makes ties go low.
    function automatic logic [FW-1:0] sel_floor(input logic [NUM_FLOORS-1:0] pend,
                                                input logic [FW-1:0] elev);
        logic [FW-1:0] best_f;
        logic [FW-1:0] best_d;
        logic [FW-1:0] f;
        logic [FW-1:0] d;
        best_f = '0;
        best_d = '1;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            f = FW'(i + 1);
            d = (f > elev) ? (f - elev) : (elev - f);
            if (pend[i] && ((best_f == '0) || (d < best_d))) begin
                best_f = f;
                best_d = d;
            end else begin
                best_f = best_f;
            end
        end
        return best_f;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FW-1:0] fl);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (fl == FW'(i + 1));
        end
        return m;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // Target selection, arrival detection and serve-clear masks.
    always_comb begin
        elev_valid_s  = (elev_f_i != '0) && (elev_f_i <= TOP_FLOOR);
        hall_sel_s    = sel_floor(hall_pend_o, elev_f_i);
        cab_sel_s     = sel_floor(cab_pend_o, elev_f_i);
        call_arrive_s = (state_r == CALL) && elev_valid_s && !busy_i &&
                        (elev_f_i == pass_f_o);
        ride_arrive_s = (state_r == RIDE) && (butt_el_o != '0) && elev_valid_s &&
                        !busy_i && (elev_f_i == butt_el_o);
        if (call_arrive_s) begin
            hall_clr_s = floor_mask(pass_f_o);
        end else begin
            hall_clr_s = '0;
        end
        if (ride_arrive_s) begin
            cab_clr_s = floor_mask(butt_el_o);
        end else begin
            cab_clr_s = '0;
        end
    end

    // Pending registers, dispatch FSM, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            hall_pend_o <= '0;
            cab_pend_o  <= '0;
            pass_f_o    <= '0;
            butt_el_o   <= '0;
            done_o      <= 1'b0;
            tmo_o       <= 1'b0;
        end else begin
            // a press landing on the bit being served keeps it pending
            hall_pend_o <= (hall_pend_o & ~hall_clr_s) | hall_btn;
            cab_pend_o  <= (cab_pend_o & ~cab_clr_s) | cab_btn;
            done_o      <= 1'b0;
            tmo_o       <= 1'b0;
            case (state_r)
                IDLE: begin
                    butt_el_o <= '0;
                    cnt_r     <= '0;
                    if (hall_pend_o != '0) begin
                        pass_f_o <= hall_sel_s;
                        state_r  <= CALL;
                    end else begin
                        pass_f_o <= '0;
                        state_r  <= IDLE;
                    end
                end
                CALL: begin
                    if (call_arrive_s) begin
                        pass_f_o <= '0;
                        cnt_r    <= '0;
                        state_r  <= RIDE;
                    end else if (cnt_r == TMO_LAST) begin
                        pass_f_o <= '0;
                        tmo_o    <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r    <= sat_inc(cnt_r);
                    end
                end
                RIDE: begin
                    if (butt_el_o == '0) begin
                        if (cab_pend_o != '0) begin
                            butt_el_o <= cab_sel_s;
                            cnt_r     <= '0;
                        end else if (cnt_r == WAIT_LAST) begin
                            cnt_r     <= '0;
                            state_r   <= IDLE;
                        end else begin
                            cnt_r     <= sat_inc(cnt_r);
                        end
                    end else if (ride_arrive_s) begin
                        butt_el_o <= '0;
                        done_o    <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= DONE;
                    end else if (cnt_r == TMO_LAST) begin
                        butt_el_o <= '0;
                        tmo_o     <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r     <= sat_inc(cnt_r);
                    end
                end
                DONE: begin
                    pass_f_o  <= '0;
                    butt_el_o <= '0;
                    cnt_r     <= '0;
                    state_r   <= IDLE;
                end
                default: begin
                    pass_f_o  <= '0;
                    butt_el_o <= '0;
                    cnt_r     <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_call_dispatch.sv
// Vector-table bench for lift_call_dispatch: each record drives one cycle of inputs
// and carries the outputs expected after that clock edge.
module tb_lift_call_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hall_btn;
    logic [6:0] cab_btn;
    logic [2:0] elev_f_i;
    logic       busy_i;
    logic [2:0] pass_f_o;
    logic [2:0] butt_el_o;
    logic [6:0] hall_pend_o;
    logic [6:0] cab_pend_o;
    logic       done_o;
    logic       tmo_o;

    lift_call_dispatch dut (
        .clk        (clk),
        .rst        (rst),
        .hall_btn   (hall_btn),
        .cab_btn    (cab_btn),
        .elev_f_i   (elev_f_i),
        .busy_i     (busy_i),
        .pass_f_o   (pass_f_o),
        .butt_el_o  (butt_el_o),
        .hall_pend_o(hall_pend_o),
        .cab_pend_o (cab_pend_o),
        .done_o     (done_o),
        .tmo_o      (tmo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [6:0] hall;
        logic [6:0] cab;
        logic [2:0] elev;
        logic       busy;
        logic [21:0] exp;   // {pass, butt, hall_pend, cab_pend, done, tmo}
    } vec_t;

    vec_t        tbl[$];
    logic [21:0] exp_q[$];
    int          nvec = 0;
    int          nerr = 0;

    function automatic void add(input logic r, input logic [6:0] h, input logic [6:0] c,
                                input logic [2:0] e, input logic b,
                                input logic [2:0] p, input logic [2:0] bt,
                                input logic [6:0] hp, input logic [6:0] cp,
                                input logic d, input logic t);
        vec_t v;
        v.rst  = r;
        v.hall = h;
        v.cab  = c;
        v.elev = e;
        v.busy = b;
        v.exp  = {p, bt, hp, cp, d, t};
        tbl.push_back(v);
    endfunction

    initial begin
        logic [21:0] got;
        logic [21:0] want;

        // reset, and presses during reset are ignored
        add(1'b1, 7'h00, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        add(1'b1, 7'h7F, 7'h7F, 3'd1, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // hall call floor 5 from floor 1, busy delays arrival
        add(1'b0, 7'h10, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h10, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd5, 3'd0, 7'h10, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd5, 1'b1, 3'd5, 3'd0, 7'h10, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd5, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // cabin call to floor 7, trip completes with a single done pulse
        add(1'b0, 7'h00, 7'h40, 3'd5, 1'b0, 3'd0, 3'd0, 7'h00, 7'h40, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd5, 1'b0, 3'd0, 3'd7, 7'h00, 7'h40, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd7, 1'b1, 3'd0, 3'd7, 7'h00, 7'h40, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd7, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b1, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd7, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // floors 2 and 6 equidistant from 4: lower wins
        add(1'b0, 7'h22, 7'h00, 3'd4, 1'b0, 3'd0, 3'd0, 7'h22, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd4, 1'b0, 3'd2, 3'd0, 7'h22, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd2, 1'b0, 3'd0, 3'd0, 7'h20, 7'h00, 1'b0, 1'b0);
        // RIDE with no cabin press gives up after 32 cycles, then floor 6 is called
        for (int i = 0; i < 32; i++)
            add(1'b0, 7'h00, 7'h00, 3'd2, 1'b0, 3'd0, 3'd0, 7'h20, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd2, 1'b0, 3'd6, 3'd0, 7'h20, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd6, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // reset while riding to floor 6
        add(1'b0, 7'h00, 7'h20, 3'd6, 1'b1, 3'd0, 3'd0, 7'h00, 7'h20, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd6, 1'b1, 3'd0, 3'd6, 7'h00, 7'h20, 1'b0, 1'b0);
        add(1'b1, 7'h00, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // CALL for floor 3 with lift stuck at 1: timeout after 64 cycles, call kept
        add(1'b0, 7'h04, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd3, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++)
            add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd3, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd0, 3'd0, 7'h04, 7'h00, 1'b0, 1'b1);
        add(1'b0, 7'h00, 7'h00, 3'd1, 1'b0, 3'd3, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        // press floor 3 on the cycle it is served: pending bit survives
        add(1'b0, 7'h04, 7'h00, 3'd3, 1'b0, 3'd0, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++)
            add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        // call at the occupied floor: one CALL cycle
        add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd3, 3'd0, 7'h04, 7'h00, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd0, 7'h00, 7'h00, 1'b0, 1'b0);
        // cabin target never reached: RIDE timeout keeps the cab bit
        add(1'b0, 7'h00, 7'h01, 3'd3, 1'b0, 3'd0, 3'd0, 7'h00, 7'h01, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd1, 7'h00, 7'h01, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++)
            add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd1, 7'h00, 7'h01, 1'b0, 1'b0);
        add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd0, 7'h00, 7'h01, 1'b0, 1'b1);
        add(1'b0, 7'h00, 7'h00, 3'd3, 1'b0, 3'd0, 3'd0, 7'h00, 7'h01, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            rst      = tbl[i].rst;
            hall_btn = tbl[i].hall;
            cab_btn  = tbl[i].cab;
            elev_f_i = tbl[i].elev;
            busy_i   = tbl[i].busy;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            got  = {pass_f_o, butt_el_o, hall_pend_o, cab_pend_o, done_o, tmo_o};
            want = exp_q.pop_front();
            nvec++;
            if (got !== want) begin
                nerr++;
                $display("FAIL vec%0d: got pass=%0d butt=%0d hpend=%h cpend=%h done=%b tmo=%b, want pass=%0d butt=%0d hpend=%h cpend=%h done=%b tmo=%b",
                         i, got[21:19], got[18:16], got[15:9], got[8:2], got[1], got[0],
                         want[21:19], want[18:16], want[15:9], want[8:2], want[1], want[0]);
            end
            if ((pass_f_o != 3'd0) && (butt_el_o != 3'd0)) begin
                nerr++;
                $display("FAIL exclusive vec%0d: pass=%0d butt=%0d, want one of them 0",
                         i, pass_f_o, butt_el_o);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
